// File: rtl/mips_pc_pkg.sv
// Shared encodings for the multicycle PC sequencer: next-PC source codes,
// jump-field FSM states and the default reset PC.
package mips_pc_pkg;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;
  localparam logic [1:0] PCSRC_RSV = 2'b11;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    S_NOIR = 1'b0,
    S_IRV  = 1'b1
  } pc_state_e;

  // J-type target: upper nibble of the already-incremented PC, word index, byte offset.
  function automatic logic [31:0] jump_target(input logic [31:0] pc, input logic [25:0] jf);
    return {pc[31:28], jf, 2'b00};
  endfunction

endpackage

// File: rtl/pc_src_sel.sv
// Combinational next-PC selector. The reserved source code holds the
// current PC and is flagged as illegal for the caller's fault logic.
module pc_src_sel
  import mips_pc_pkg::*;
(
  input  logic [1:0]  pcsource,
  input  logic [31:0] aluresult,
  input  logic [31:0] aluout,
  input  logic [31:0] jumptarget,
  input  logic [31:0] pc,
  output logic [31:0] next_pc,
  output logic        illegal
);

  // 4:1 source mux with reserved-code decode
  always_comb begin
    next_pc = pc;
    illegal = 1'b0;
    case (pcsource)
      PCSRC_SEQ: next_pc = aluresult;
      PCSRC_BR:  next_pc = aluout;
      PCSRC_JMP: next_pc = jumptarget;
      default: begin
        next_pc = pc;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/pc_jump_seq.sv
// Program-counter sequencer: PC register, latched jump field, J-type target
// formation, redirect pulse, sticky fault and debug counters.
module pc_jump_seq
  import mips_pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             IRWrite,
  input  logic [31:0]      Instr,
  input  logic             PCWrite,
  input  logic             PCWriteCond,
  input  logic             Zero,
  input  logic [1:0]       PCSource,
  input  logic [31:0]      ALUResult,
  input  logic [31:0]      ALUOut,
  output logic [31:0]      PC,
  output logic [31:0]      JumpTarget,
  output logic             JumpSel,
  output logic             Redirect,
  output logic             Fault,
  output logic [CNT_W-1:0] InstrCount,
  output logic [CNT_W-1:0] JumpCount
);

  pc_state_e        state_p0, state_nxt;
  logic [31:0]      pc_p0;
  logic [25:0]      jfield_p0;
  logic             redirect_p0;
  logic             fault_p0;
  logic [CNT_W-1:0] icnt_p0;
  logic [CNT_W-1:0] jcnt_p0;

  logic [31:0]      next_pc;
  logic             src_illegal;
  logic             we;
  logic             jump_req;
  logic             jump_noir;
  logic             load;
  logic             instr_unused;

  // The opcode bits are decoded elsewhere; only the jump field is kept here.
  assign instr_unused = ^Instr[31:26];

  assign we         = PCWrite | (PCWriteCond & Zero);
  assign jump_req   = we & (PCSource == PCSRC_JMP);
  assign jump_noir  = jump_req & (state_p0 == S_NOIR);
  assign load       = we & ~src_illegal & ~jump_noir;

  assign JumpTarget = jump_target(pc_p0, jfield_p0);
  assign JumpSel    = (PCSource == PCSRC_JMP);
  assign PC         = pc_p0;
  assign Redirect   = redirect_p0;
  assign Fault      = fault_p0;
  assign InstrCount = icnt_p0;
  assign JumpCount  = jcnt_p0;

  pc_src_sel u_src_sel (
    .pcsource   (PCSource),
    .aluresult  (ALUResult),
    .aluout     (ALUOut),
    .jumptarget (JumpTarget),
    .pc         (pc_p0),
    .next_pc    (next_pc),
    .illegal    (src_illegal)
  );

  // Jump-field validity FSM: becomes valid on the first IRWrite, only reset clears it
  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      S_NOIR:  if (IRWrite) state_nxt = S_IRV;
      S_IRV:   state_nxt = S_IRV;
      default: state_nxt = S_NOIR;
    endcase
  end

  // FSM state register
  always_ff @(posedge Clk) begin
    if (Rst) state_p0 <= S_NOIR;
    else     state_p0 <= state_nxt;
  end

  // PC commit, jump-field latch, redirect pulse and sticky fault
  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc_p0       <= RESET_PC;
      jfield_p0   <= '0;
      redirect_p0 <= 1'b0;
      fault_p0    <= 1'b0;
    end else begin
      if (load) pc_p0 <= next_pc;
      // The jump in this same cycle already consumed the old field via JumpTarget.
      if (IRWrite) jfield_p0 <= Instr[25:0];
      redirect_p0 <= load & ((PCSource == PCSRC_BR) | (PCSource == PCSRC_JMP));
      if (we & (src_illegal | jump_noir)) fault_p0 <= 1'b1;
    end
  end

  // Debug counters, wrapping naturally at CNT_W bits
  always_ff @(posedge Clk) begin
    if (Rst) begin
      icnt_p0 <= '0;
      jcnt_p0 <= '0;
    end else begin
      if (IRWrite) icnt_p0 <= icnt_p0 + 1'b1;
      if (load && (PCSource == PCSRC_JMP)) jcnt_p0 <= jcnt_p0 + 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_jump_seq.sv
// Randomized self-checking bench for pc_jump_seq with a behavioural model.
module tb_pc_jump_seq;

  localparam logic [31:0] RPC = 32'h0040_0000;
  localparam int          CW  = 4;

  logic          Clk = 1'b0;
  logic          Rst, IRWrite, PCWrite, PCWriteCond, Zero;
  logic [31:0]   Instr, ALUResult, ALUOut;
  logic [1:0]    PCSource;
  logic [31:0]   PC, JumpTarget;
  logic          JumpSel, Redirect, Fault;
  logic [CW-1:0] InstrCount, JumpCount;

  int checks = 0;
  int failures = 0;

  // model state
  logic [31:0]   m_pc;
  logic [25:0]   m_jf;
  logic          m_have_ir, m_fault, m_redir;
  logic [CW-1:0] m_ic, m_jc;

  pc_jump_seq #(.RESET_PC(RPC), .CNT_W(CW)) dut (
    .Clk(Clk), .Rst(Rst), .IRWrite(IRWrite), .Instr(Instr),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Zero(Zero),
    .PCSource(PCSource), .ALUResult(ALUResult), .ALUOut(ALUOut),
    .PC(PC), .JumpTarget(JumpTarget), .JumpSel(JumpSel),
    .Redirect(Redirect), .Fault(Fault),
    .InstrCount(InstrCount), .JumpCount(JumpCount)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Architectural effect of one clock edge, applied from the current inputs.
  task automatic model_edge();
    logic        we;
    logic [31:0] tgt;
    if (Rst) begin
      m_pc = RPC; m_jf = '0; m_have_ir = 1'b0; m_fault = 1'b0;
      m_ic = '0; m_jc = '0; m_redir = 1'b0;
      return;
    end
    we  = PCWrite || (PCWriteCond && Zero);
    tgt = {m_pc[31:28], m_jf, 2'b00};
    m_redir = 1'b0;
    if (we) begin
      if (PCSource == 2'd0) m_pc = ALUResult;
      else if (PCSource == 2'd1) begin m_pc = ALUOut; m_redir = 1'b1; end
      else if (PCSource == 2'd2) begin
        if (m_have_ir) begin m_pc = tgt; m_jc = m_jc + 1; m_redir = 1'b1; end
        else m_fault = 1'b1;
      end else m_fault = 1'b1;
    end
    if (IRWrite) begin m_jf = Instr[25:0]; m_have_ir = 1'b1; m_ic = m_ic + 1; end
  endtask

  task automatic check_state();
    chk("PC", PC, m_pc);
    chk("Redirect", {31'b0, Redirect}, {31'b0, m_redir});
    chk("Fault", {31'b0, Fault}, {31'b0, m_fault});
    chk("InstrCount", {28'b0, InstrCount}, {28'b0, m_ic});
    chk("JumpCount", {28'b0, JumpCount}, {28'b0, m_jc});
    chk("JumpTarget", JumpTarget, {m_pc[31:28], m_jf, 2'b00});
  endtask

  // Inputs already applied: check combinational outputs, clock, check state.
  task automatic cyc();
    #1;
    chk("JumpSel", {31'b0, JumpSel}, {31'b0, (PCSource == 2'd2)});
    @(posedge Clk);
    model_edge();
    #1;
    check_state();
  endtask

  task automatic idle();
    Rst = 0; IRWrite = 0; PCWrite = 0; PCWriteCond = 0; Zero = 0;
    PCSource = 2'd0; Instr = '0; ALUResult = '0; ALUOut = '0;
  endtask

  initial begin
    idle();
    m_pc = '0; m_jf = '0; m_have_ir = 0; m_fault = 0; m_ic = '0; m_jc = '0; m_redir = 0;
    @(posedge Clk); #1;

    // reset for two cycles
    Rst = 1; cyc(); cyc();
    chk("rst_pc_const", PC, 32'h0040_0000);
    chk("rst_jt_const", JumpTarget, 32'h0000_0000);
    Rst = 0;

    // fetch then jump
    IRWrite = 1; Instr = 32'h0810_0004; PCWrite = 1; PCSource = 2'd0; ALUResult = 32'h0040_0004;
    cyc();
    chk("fetch_pc_const", PC, 32'h0040_0004);
    idle(); PCWrite = 1; PCSource = 2'd2;
    cyc();
    chk("jump_pc_const", PC, 32'h0040_0010);
    chk("jump_redir_const", {31'b0, Redirect}, 32'd1);
    idle(); cyc();
    chk("redir_drop_const", {31'b0, Redirect}, 32'd0);

    // branch taken then not taken
    PCWriteCond = 1; Zero = 1; PCSource = 2'd1; ALUOut = 32'h0040_0100; cyc();
    chk("br_pc_const", PC, 32'h0040_0100);
    Zero = 0; ALUOut = 32'h0040_0200; cyc();
    chk("brnt_pc_const", PC, 32'h0040_0100);
    idle();

    // simultaneous IRWrite and jump: old field 26'h4 used
    IRWrite = 1; Instr = 32'h0000_0004; cyc();
    IRWrite = 1; Instr = 32'h0800_0008; PCWrite = 1; PCSource = 2'd2; cyc();
    chk("simul_pc_const", PC, 32'h0000_0010);
    idle(); cyc();
    chk("simul_jt_const", JumpTarget, 32'h0000_0020);

    // reserved source faults and holds
    PCWrite = 1; PCSource = 2'd3; ALUResult = 32'h1234_5678; cyc();
    idle(); cyc(); cyc();

    // jump before any IRWrite, including first IRWrite with a simultaneous jump
    Rst = 1; cyc(); idle();
    PCWrite = 1; PCSource = 2'd2; cyc();
    IRWrite = 1; Instr = 32'h0812_3456; cyc();
    idle(); cyc();

    // counter wrap after 16 IRWrites
    Rst = 1; cyc(); idle();
    for (int i = 0; i < 16; i++) begin IRWrite = 1; Instr = $urandom; cyc(); end
    idle();
    chk("wrap_ic_const", {28'b0, InstrCount}, 32'd0);

    // reset together with a write
    Rst = 1; PCWrite = 1; PCSource = 2'd1; ALUOut = 32'hdead_beec; cyc();
    chk("rst_prio_const", PC, RPC);
    idle();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      Rst         = ($urandom_range(0, 49) == 0);
      IRWrite     = ($urandom_range(0, 3) == 0);
      Instr       = $urandom;
      PCWrite     = ($urandom_range(0, 2) == 0);
      PCWriteCond = ($urandom_range(0, 2) == 0);
      Zero        = $urandom_range(0, 1);
      PCSource    = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      ALUResult   = ($urandom_range(0, 1) != 0) ? PC + 32'd4 : $urandom;
      ALUOut      = $urandom;
      cyc();
    end
    idle(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
